// File: rtl/dat_sched_pkg.sv
// Shared definitions for the SD DAT multi-block scheduler.
//  - state_e         : scheduler FSM encoding (ST_STOP only reachable with DAT_AUTO_STOP_EN)
//  - DIR_WRITE/READ  : write_read encodings
//  - GAP_CYCLES_DEF  : default idle cycles between consecutive blocks
package dat_sched_pkg;

  localparam int unsigned STATE_W        = 4;
  localparam int unsigned GAP_CYCLES_DEF = 2;

  localparam logic DIR_WRITE = 1'b1;  // FIFO -> card
  localparam logic DIR_READ  = 1'b0;  // card -> FIFO

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 4'd0,
    ST_WAIT_FIFO = 4'd1,
    ST_ISSUE     = 4'd2,
    ST_ACTIVE    = 4'd3,
    ST_ACK       = 4'd4,
    ST_GAP       = 4'd5,
    ST_DONE      = 4'd6,
    ST_ERROR     = 4'd7,
    ST_STOP      = 4'd8
  } state_e;

  // A block is in flight from its strobe until its ack handshake ends.
  function automatic logic in_flight(input state_e s);
    return (s == ST_ISSUE) || (s == ST_ACTIVE) || (s == ST_ACK);
  endfunction

endpackage

// File: rtl/dat_timeout_counter.sv
// Per-block data timeout counter.
// Ports:
//  sd_clock, reset : clock, synchronous active-high reset
//  clear           : zero the count (wins over enable)
//  enable          : count one cycle
//  limit           : timeout in cycles; 0 never expires
//  expired_c       : combinational, high on the enabled cycle where count == limit-1
module dat_timeout_counter #(
  parameter int unsigned TIMEOUT_W = 64
) (
  input  logic                 sd_clock,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 enable,
  input  logic [TIMEOUT_W-1:0] limit,
  output logic                 expired_c
);

  logic [TIMEOUT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + TIMEOUT_W'(1);
    end
  end

  always_ff @(posedge sd_clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_c = enable && (limit != '0) && (count_q == (limit - TIMEOUT_W'(1)));

endmodule

// File: rtl/dat_block_scheduler.sv
// Sequences multi-block SD DAT transfers over the single-block dat_phys layer.
// Optional feature: define DAT_AUTO_STOP_EN to add a STOP phase (stop_req/stop_ack)
// after the last block of a multiple-block transfer.
// Ports:
//  sd_clock, reset            : clock, synchronous active-high reset
//  start, abort               : transfer request (IDLE only) / abort (any active state)
//  write_read, multiple,
//  block_count, timeout_reg   : transfer config, latched at accepted start
//  fifo_empty, fifo_full      : FIFO readiness for write / read blocks
//  phy_strobe, phy_complete,
//  phy_ack, phy_ack_in,
//  phy_idle                   : dat_phys block handshake
//  busy, xfer_done,
//  xfer_error, data_timeout,
//  blocks_done                : host status
//  stop_req, stop_ack         : auto-stop handshake (DAT_AUTO_STOP_EN only)
module dat_block_scheduler
  import dat_sched_pkg::*;
#(
  parameter int unsigned BLKCNT_W   = 16,
  parameter int unsigned TIMEOUT_W  = 64,
  parameter int unsigned GAP_CYCLES = GAP_CYCLES_DEF
) (
  input  logic                 sd_clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 write_read,
  input  logic                 multiple,
  input  logic [BLKCNT_W-1:0]  block_count,
  input  logic [TIMEOUT_W-1:0] timeout_reg,
  input  logic                 fifo_empty,
  input  logic                 fifo_full,
  output logic                 phy_strobe,
  input  logic                 phy_complete,
  output logic                 phy_ack,
  input  logic                 phy_ack_in,
  output logic                 phy_idle,
  output logic                 busy,
  output logic                 xfer_done,
  output logic                 xfer_error,
  output logic                 data_timeout,
`ifdef DAT_AUTO_STOP_EN
  output logic                 stop_req,
  input  logic                 stop_ack,
`endif
  output logic [BLKCNT_W-1:0]  blocks_done
);

  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  state_e               state_q, state_d;
  logic [BLKCNT_W-1:0]  blocks_done_q, blocks_done_d;
  logic [BLKCNT_W-1:0]  target_q, target_d;
  logic [TIMEOUT_W-1:0] limit_q, limit_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic                 wr_q, wr_d;
  logic                 data_timeout_q, data_timeout_d;
  logic                 fifo_empty_q, fifo_full_q;
  logic                 phy_strobe_q, phy_ack_q, phy_idle_q, busy_q;
  logic                 xfer_done_q, xfer_error_q;
`ifdef DAT_AUTO_STOP_EN
  logic                 multiple_q, multiple_d;
  logic                 stop_req_q;
`endif

  logic [BLKCNT_W-1:0]  start_target;
  logic                 fifo_ready;
  logic                 tmo_expired;
  logic                 abort_hit;

  // Single-block requests always move exactly one block.
  assign start_target = multiple ? block_count : BLKCNT_W'(1);

  // DONE/ERROR already terminate the transfer, so abort only matters before them.
  assign abort_hit = abort && (state_q != ST_IDLE) && (state_q != ST_DONE) && (state_q != ST_ERROR);

  // FIFO flags are registered; a release reaches phy_strobe two cycles later.
  always_comb begin
    fifo_ready = 1'b0;
    case (wr_q)
      DIR_WRITE: fifo_ready = !fifo_empty_q;
      DIR_READ:  fifo_ready = !fifo_full_q;
      default:   fifo_ready = 1'b0;
    endcase
  end

  dat_timeout_counter #(
    .TIMEOUT_W (TIMEOUT_W)
  ) u_timeout (
    .sd_clock  (sd_clock),
    .reset     (reset),
    .clear     (state_q == ST_ISSUE),
    .enable    (state_q == ST_ACTIVE),
    .limit     (limit_q),
    .expired_c (tmo_expired)
  );

  // Next-state and transfer bookkeeping.
  always_comb begin
    state_d        = state_q;
    blocks_done_d  = blocks_done_q;
    data_timeout_d = data_timeout_q;
    wr_d           = wr_q;
    target_d       = target_q;
    limit_d        = limit_q;
    gap_d          = gap_q;
`ifdef DAT_AUTO_STOP_EN
    multiple_d     = multiple_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          wr_d           = write_read;
          target_d       = start_target;
          limit_d        = timeout_reg;
          blocks_done_d  = '0;
          data_timeout_d = 1'b0;
`ifdef DAT_AUTO_STOP_EN
          multiple_d     = multiple;
`endif
          state_d        = (start_target == '0) ? ST_DONE : ST_WAIT_FIFO;
        end
      end
      ST_WAIT_FIFO: begin
        if (fifo_ready) begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        // Completion beats a coincident timeout.
        if (phy_complete) begin
          blocks_done_d = blocks_done_q + BLKCNT_W'(1);
          state_d       = ST_ACK;
        end else if (tmo_expired) begin
          data_timeout_d = 1'b1;
          state_d        = ST_ERROR;
        end
      end
      ST_ACK: begin
        if (phy_ack_in) begin
          if (blocks_done_q == target_q) begin
`ifdef DAT_AUTO_STOP_EN
            state_d = multiple_q ? ST_STOP : ST_DONE;
`else
            state_d = ST_DONE;
`endif
          end else begin
            gap_d   = '0;
            state_d = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
          state_d = ST_WAIT_FIFO;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
`ifdef DAT_AUTO_STOP_EN
      ST_STOP: begin
        if (stop_ack) begin
          state_d = ST_DONE;
        end
      end
`endif
      ST_DONE:  state_d = ST_IDLE;
      ST_ERROR: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    if (abort_hit) begin
      state_d        = ST_ERROR;
      blocks_done_d  = blocks_done_q;
      data_timeout_d = data_timeout_q;
    end
  end

  // State, config and registered outputs (decoded from the next state).
  always_ff @(posedge sd_clock) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      blocks_done_q  <= '0;
      data_timeout_q <= 1'b0;
      wr_q           <= DIR_READ;
      target_q       <= '0;
      limit_q        <= '0;
      gap_q          <= '0;
      fifo_empty_q   <= 1'b1;
      fifo_full_q    <= 1'b0;
      phy_strobe_q   <= 1'b0;
      phy_ack_q      <= 1'b0;
      phy_idle_q     <= 1'b1;
      busy_q         <= 1'b0;
      xfer_done_q    <= 1'b0;
      xfer_error_q   <= 1'b0;
`ifdef DAT_AUTO_STOP_EN
      multiple_q     <= 1'b0;
      stop_req_q     <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      blocks_done_q  <= blocks_done_d;
      data_timeout_q <= data_timeout_d;
      wr_q           <= wr_d;
      target_q       <= target_d;
      limit_q        <= limit_d;
      gap_q          <= gap_d;
      fifo_empty_q   <= fifo_empty;
      fifo_full_q    <= fifo_full;
      phy_strobe_q   <= (state_d == ST_ISSUE);
      phy_ack_q      <= (state_d == ST_ACK);
      phy_idle_q     <= !in_flight(state_d);
      busy_q         <= (state_d != ST_IDLE);
      xfer_done_q    <= (state_d == ST_DONE);
      xfer_error_q   <= (state_d == ST_ERROR);
`ifdef DAT_AUTO_STOP_EN
      multiple_q     <= multiple_d;
      stop_req_q     <= (state_d == ST_STOP);
`endif
    end
  end

  assign phy_strobe   = phy_strobe_q;
  assign phy_ack      = phy_ack_q;
  assign phy_idle     = phy_idle_q;
  assign busy         = busy_q;
  assign xfer_done    = xfer_done_q;
  assign xfer_error   = xfer_error_q;
  assign data_timeout = data_timeout_q;
  assign blocks_done  = blocks_done_q;
`ifdef DAT_AUTO_STOP_EN
  assign stop_req     = stop_req_q;
`endif

endmodule

// File: tb/tb_dat_block_scheduler.sv
// Self-checking bench for dat_block_scheduler: transfer table plus hand-written
// sequences for FIFO stall, start-while-busy, abort and idle abort.
module tb_dat_block_scheduler;

  localparam int unsigned BLKCNT_W  = 16;
  localparam int unsigned TIMEOUT_W = 64;

  logic                 sd_clock, reset, start, abort, write_read, multiple;
  logic [BLKCNT_W-1:0]  block_count;
  logic [TIMEOUT_W-1:0] timeout_reg;
  logic                 fifo_empty, fifo_full;
  logic                 phy_strobe, phy_complete, phy_ack, phy_ack_in, phy_idle;
  logic                 busy, xfer_done, xfer_error, data_timeout;
  logic [BLKCNT_W-1:0]  blocks_done;
`ifdef DAT_AUTO_STOP_EN
  logic                 stop_req, stop_ack;
`endif

  typedef struct {
    logic wr; logic mult; int cnt; int tmo; int dly;
    logic err; int blocks; logic dtmo; int strobes;
  } vec_t;

  typedef struct { logic err; int blocks; logic dtmo; int strobes; } exp_t;

  exp_t sb[$];
  vec_t vecs[8];

  int tests = 0, fails = 0, cyc = 0;
  int strobe_cnt = 0, first_strobe_cyc = 0, last_strobe_cyc = 0, spacing = 0;
  int end_cyc = 0, start_cyc = 0, phy_cnt = 0, cpl_delay = 0;
  bit end_seen = 0;

  dat_block_scheduler #(
    .BLKCNT_W   (BLKCNT_W),
    .TIMEOUT_W  (TIMEOUT_W),
    .GAP_CYCLES (2)
  ) dut (
    .sd_clock     (sd_clock),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .write_read   (write_read),
    .multiple     (multiple),
    .block_count  (block_count),
    .timeout_reg  (timeout_reg),
    .fifo_empty   (fifo_empty),
    .fifo_full    (fifo_full),
    .phy_strobe   (phy_strobe),
    .phy_complete (phy_complete),
    .phy_ack      (phy_ack),
    .phy_ack_in   (phy_ack_in),
    .phy_idle     (phy_idle),
    .busy         (busy),
    .xfer_done    (xfer_done),
    .xfer_error   (xfer_error),
    .data_timeout (data_timeout),
`ifdef DAT_AUTO_STOP_EN
    .stop_req     (stop_req),
    .stop_ack     (stop_ack),
`endif
    .blocks_done  (blocks_done)
  );

  initial begin
    sd_clock = 1'b0;
    forever #5 sd_clock = ~sd_clock;
  end

  initial forever @(posedge sd_clock) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor, scoreboard pop and dat_phys model, all on the falling edge.
  initial forever begin
    @(negedge sd_clock);
    if (reset) begin
      phy_cnt      = 0;
      phy_complete = 1'b0;
      phy_ack_in   = 1'b0;
    end else begin
      if (phy_strobe) begin
        strobe_cnt++;
        if (strobe_cnt == 1) first_strobe_cyc = cyc;
        else spacing = cyc - last_strobe_cyc;
        last_strobe_cyc = cyc;
      end
      if (xfer_done || xfer_error) begin
        exp_t e;
        end_seen = 1;
        end_cyc  = cyc;
        if (sb.size() == 0) begin
          check("unexpected_end_pulse", 1, 0);
        end else begin
          e = sb.pop_front();
          check("end_is_error", int'(xfer_error), int'(e.err));
          check("end_pulse_exclusive", int'(xfer_done & xfer_error), 0);
          check("blocks_done", int'(blocks_done), e.blocks);
          check("data_timeout", int'(data_timeout), int'(e.dtmo));
          check("strobe_count", strobe_cnt, e.strobes);
        end
      end
      // Completion pulse during the dly-th ACTIVE cycle; dly 0 never completes.
      if (phy_strobe) begin
        phy_cnt      = cpl_delay;
        phy_complete = 1'b0;
      end else if (phy_cnt > 0) begin
        phy_cnt--;
        phy_complete = (phy_cnt == 0);
      end else begin
        phy_complete = 1'b0;
      end
      phy_ack_in = phy_ack;
`ifdef DAT_AUTO_STOP_EN
      stop_ack = stop_req;
`endif
    end
  end

  task automatic launch(input vec_t v, input logic fe, input logic ff);
    exp_t e;
    @(negedge sd_clock);
    write_read  = v.wr;
    multiple    = v.mult;
    block_count = 16'(v.cnt);
    timeout_reg = 64'(v.tmo);
    cpl_delay   = v.dly;
    fifo_empty  = fe;
    fifo_full   = ff;
    e = '{v.err, v.blocks, v.dtmo, v.strobes};
    sb.push_back(e);
    strobe_cnt = 0;
    end_seen   = 0;
    start      = 1'b1;
    start_cyc  = cyc;
    @(negedge sd_clock);
    start = 1'b0;
    check("busy_after_start", int'(busy), 1);
    check("data_timeout_cleared_by_start", int'(data_timeout), 0);
  endtask

  task automatic wait_end(input int budget);
    for (int i = 0; i < budget && !end_seen; i++) @(negedge sd_clock);
    if (!end_seen) begin
      check("end_pulse_within_budget", 0, 1);
      sb.delete();
    end
  endtask

  task automatic post_end_checks();
    while (cyc <= end_cyc) @(negedge sd_clock);
    check("busy_low_after_end", int'(busy), 0);
    check("end_pulse_one_cycle", int'(xfer_done | xfer_error), 0);
    check("phy_idle_after_end", int'(phy_idle), 1);
  endtask

  task automatic run_vec(input vec_t v);
    launch(v, 1'b0, 1'b0);
    wait_end(3000);
    if (v.strobes > 0) check("start_to_strobe", first_strobe_cyc - start_cyc, 2);
    if (v.strobes == 0) check("zero_block_done_latency", end_cyc - start_cyc, 1);
    if (v.strobes > 1 && !v.err) check("strobe_spacing", spacing, v.dly + 5);
    if (v.err && v.dtmo) check("timeout_cycle", end_cyc - last_strobe_cyc, v.tmo + 1);
    post_end_checks();
  endtask

  task automatic run_fifo_stall(input logic wr, input int hold);
    vec_t v;
    int   rel_cyc;
    v = '{wr, 1'b0, 1, 10, 5, 1'b0, 1, 1'b0, 1};
    launch(v, 1'b1, !wr);
    repeat (hold) @(negedge sd_clock);
    check("fifo_stall_no_strobe", strobe_cnt, 0);
    check("fifo_stall_busy", int'(busy), 1);
    if (wr) fifo_empty = 1'b0;
    else    fifo_full  = 1'b0;
    rel_cyc = cyc;
    wait_end(500);
    check("fifo_release_to_strobe", first_strobe_cyc - rel_cyc, 2);
    post_end_checks();
    fifo_empty = 1'b0;
    fifo_full  = 1'b0;
  endtask

  initial begin
    vec_t v;
    int   abort_cyc;
    reset = 1'b1; start = 1'b0; abort = 1'b0; write_read = 1'b0; multiple = 1'b0;
    block_count = '0; timeout_reg = '0; fifo_empty = 1'b0; fifo_full = 1'b0;
    phy_complete = 1'b0; phy_ack_in = 1'b0;
`ifdef DAT_AUTO_STOP_EN
    stop_ack = 1'b0;
`endif

    //        wr    mult  cnt tmo dly  err   blk dtmo  strobes
    vecs[0] = '{1'b1, 1'b1, 3, 0, 20, 1'b0, 3, 1'b0, 3};  // write x3
    vecs[1] = '{1'b0, 1'b0, 5, 0, 7,  1'b0, 1, 1'b0, 1};  // single ignores count
    vecs[2] = '{1'b1, 1'b1, 3, 10, 0, 1'b1, 0, 1'b1, 1};  // timeout, block 1
    vecs[3] = '{1'b0, 1'b1, 0, 0, 5,  1'b0, 0, 1'b0, 0};  // zero blocks
    vecs[4] = '{1'b1, 1'b0, 0, 0, 3,  1'b0, 1, 1'b0, 1};  // single, count 0
    vecs[5] = '{1'b0, 1'b1, 2, 10, 10, 1'b0, 2, 1'b0, 2}; // complete == timeout
    vecs[6] = '{1'b1, 1'b1, 2, 5, 6,  1'b1, 0, 1'b1, 1};  // timeout before complete
    vecs[7] = '{1'b0, 1'b1, 3, 0, 1,  1'b0, 3, 1'b0, 3};  // shortest blocks

    repeat (3) @(negedge sd_clock);
    reset = 1'b0;
    @(negedge sd_clock);
    check("reset_phy_idle", int'(phy_idle), 1);
    check("reset_busy", int'(busy), 0);
    check("reset_blocks_done", int'(blocks_done), 0);
    check("reset_phy_strobe", int'(phy_strobe), 0);
    check("reset_phy_ack", int'(phy_ack), 0);
    check("reset_xfer_done", int'(xfer_done), 0);
    check("reset_xfer_error", int'(xfer_error), 0);
    check("reset_data_timeout", int'(data_timeout), 0);

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i]);
      if (vecs[i].dtmo) begin
        repeat (4) @(negedge sd_clock);
        check("data_timeout_sticky", int'(data_timeout), 1);
      end
    end

    run_fifo_stall(1'b1, 50);
    run_fifo_stall(1'b0, 20);

    // start while busy must not relatch config (read + fifo_full would stall).
    v = '{1'b1, 1'b1, 3, 0, 20, 1'b0, 3, 1'b0, 3};
    launch(v, 1'b0, 1'b0);
    for (int i = 0; i < 200 && strobe_cnt < 1; i++) @(negedge sd_clock);
    repeat (3) @(negedge sd_clock);
    write_read = 1'b0; multiple = 1'b0; block_count = 16'd1; fifo_full = 1'b1;
    start = 1'b1;
    @(negedge sd_clock);
    start = 1'b0;
    wait_end(500);
    post_end_checks();
    fifo_full = 1'b0;

    // Abort in block 2 of 4, then a start as soon as IDLE returns.
    v = '{1'b1, 1'b1, 4, 0, 20, 1'b1, 1, 1'b0, 2};
    launch(v, 1'b0, 1'b0);
    for (int i = 0; i < 500 && strobe_cnt < 2; i++) @(negedge sd_clock);
    check("abort_reached_block2", strobe_cnt, 2);
    repeat (5) @(negedge sd_clock);
    abort     = 1'b1;
    abort_cyc = cyc;
    @(negedge sd_clock);
    abort = 1'b0;
    wait_end(100);
    check("abort_to_error", end_cyc - abort_cyc, 1);
    while (cyc <= end_cyc) @(negedge sd_clock);
    check("abort_back_to_idle", int'(busy), 0);
    run_vec(vecs[1]);

    // abort in IDLE is ignored.
    @(negedge sd_clock);
    abort = 1'b1;
    @(negedge sd_clock);
    abort = 1'b0;
    repeat (2) @(negedge sd_clock);
    check("abort_idle_no_activity", int'(busy | xfer_error), 0);
    check("scoreboard_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
